// File: rtl/regfile_pkg.sv
// Shared constants and types for the bypassed, scoreboarded register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int DEPTH_DEF  = 16;
    localparam int SEL_W_DEF  = $clog2(DEPTH_DEF);
    localparam int REG_ZERO   = 0;

    typedef logic [SEL_W_DEF-1:0] reg_sel_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits with mark-over-write priority and registered busy lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEPTH_DEF,
    parameter int ZERO_REG = 0,
    parameter int SEL_W    = $clog2(DEPTH)
) (
    input  logic             i_clock,
    input  logic             i_reset_n,
    input  logic             i_write_en,
    input  logic [SEL_W-1:0] i_write_sel,
    input  logic             i_mark_en,
    input  logic [SEL_W-1:0] i_mark_sel,
    input  logic             i_read_en,
    input  logic [SEL_W-1:0] i_sel_a,
    input  logic [SEL_W-1:0] i_sel_b,
    output logic [DEPTH-1:0] o_pending,
    output logic             o_busy_a,
    output logic             o_busy_b
);

    logic [DEPTH-1:0] r_pending;
    logic [DEPTH-1:0] w_pending_nxt;
    logic             r_busy_a;
    logic             r_busy_b;

    // Clear first, then set: a new producer issued alongside a writeback keeps the bit.
    always_comb begin
        w_pending_nxt = r_pending;
        if (i_write_en) w_pending_nxt[i_write_sel] = 1'b0;
        if (i_mark_en)  w_pending_nxt[i_mark_sel]  = 1'b1;
        if (ZERO_REG != 0) w_pending_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pending <= '0;
            r_busy_a  <= 1'b0;
            r_busy_b  <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            if (i_read_en) begin
                r_busy_a <= w_pending_nxt[i_sel_a];
                r_busy_b <= w_pending_nxt[i_sel_b];
            end
        end
    end

    assign o_pending = r_pending;
    assign o_busy_a  = r_busy_a;
    assign o_busy_b  = r_busy_b;

endmodule

// File: rtl/regfile_bypass_sb.sv
// Two-read/one-write register file with write-first bypass and a pending scoreboard
// so decode can stall on in-flight multi-cycle results.
module regfile_bypass_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int SEL_W    = $clog2(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WriteEnable,
    input  logic [SEL_W-1:0]  SelectInput,
    input  logic [DATA_W-1:0] In,
    input  logic              ReadEnable,
    input  logic [SEL_W-1:0]  SelectA,
    input  logic [SEL_W-1:0]  SelectB,
    input  logic              MarkEnable,
    input  logic [SEL_W-1:0]  MarkSelect,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              ABusy,
    output logic              BBusy,
    output logic [DEPTH-1:0]  PendingVec
);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic              w_wr_ok;
    logic              w_hit_a;
    logic              w_hit_b;

    // A suppressed register-0 write neither lands nor bypasses; R0 stays at its reset 0.
    assign w_wr_ok = WriteEnable && !((ZERO_REG != 0) && (SelectInput == SEL_W'(REG_ZERO)));
    assign w_hit_a = w_wr_ok && (SelectInput == SelectA);
    assign w_hit_b = w_wr_ok && (SelectInput == SelectB);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
        end else if (w_wr_ok) begin
            r_regs[SelectInput] <= In;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_a <= '0;
            r_b <= '0;
        end else if (ReadEnable) begin
            r_a <= w_hit_a ? In : r_regs[SelectA];
            r_b <= w_hit_b ? In : r_regs[SelectB];
        end
    end

    regfile_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .SEL_W    (SEL_W)
    ) u_scoreboard (
        .i_clock     (Clock),
        .i_reset_n   (Reset),
        .i_write_en  (WriteEnable),
        .i_write_sel (SelectInput),
        .i_mark_en   (MarkEnable),
        .i_mark_sel  (MarkSelect),
        .i_read_en   (ReadEnable),
        .i_sel_a     (SelectA),
        .i_sel_b     (SelectB),
        .o_pending   (PendingVec),
        .o_busy_a    (ABusy),
        .o_busy_b    (BBusy)
    );

    assign A = r_a;
    assign B = r_b;

endmodule
